// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipe: load-use bubbles, ID-stage redirect flushes
// and whole-pipe freezes on data-memory waits, with timeout and saturating perf counters.
module hazard_stall_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_rs_ifid,
    input  logic [4:0]       i_rt_ifid,
    input  logic             i_uses_rt_ifid,
    input  logic             i_mem_read_idex,
    input  logic [4:0]       i_rt_idex,
    input  logic             i_branch_taken_id,
    input  logic             i_jump_id,
    input  logic             i_mem_access_exmem,
    input  logic             i_mem_ready,
    input  logic             i_clear_counters,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_write,
    output logic             o_idex_flush,
    output logic             o_exmem_write,
    output logic             o_memwb_bubble,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count,
    output logic             o_mem_timeout,
    output logic             o_halted
);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

    state_t           r_state, w_state_nxt;
    logic [WC_W-1:0]  r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             r_timeout;
    logic             w_timeout_set;
    logic             w_freeze;
    logic             w_lu;
    logic             w_redirect;

    assign w_lu = i_mem_read_idex && (i_rt_idex != 5'd0) &&
                  ((i_rt_idex == i_rs_ifid) || (i_uses_rt_ifid && (i_rt_idex == i_rt_ifid)));
    assign w_redirect = i_branch_taken_id || i_jump_id;

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_set = 1'b0;
        w_freeze      = 1'b0;
        case (r_state)
            S_RUN: begin
                w_freeze = i_mem_access_exmem && !i_mem_ready;
                if (w_freeze) begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = WC_W'(1);
                end
            end
            S_WAIT: begin
                // Once the access is in flight only mem_ready matters.
                w_freeze = !i_mem_ready;
                if (i_mem_ready) begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == WC_W'(TIMEOUT - 1)) begin
                    w_state_nxt   = S_HALT;
                    w_wait_nxt    = '0;
                    w_timeout_set = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt + WC_W'(1);
                end
            end
            S_HALT: w_freeze = 1'b1;
            default: begin
                w_state_nxt = S_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        o_pc_write     = 1'b1;
        o_ifid_write   = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_write   = 1'b1;
        o_idex_flush   = 1'b0;
        o_exmem_write  = 1'b1;
        o_memwb_bubble = 1'b0;
        if (i_rst) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_write  = 1'b0;
            o_exmem_write = 1'b0;
        end else if (w_freeze) begin
            o_pc_write     = 1'b0;
            o_ifid_write   = 1'b0;
            o_idex_write   = 1'b0;
            o_exmem_write  = 1'b0;
            o_memwb_bubble = 1'b1;
        end else if (w_lu) begin
            // Branch operands are not ready yet, so a concurrent redirect waits.
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
        end else if (w_redirect) begin
            o_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout_set) r_timeout <= 1'b1;
            if (i_clear_counters) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if ((w_freeze || w_lu) && (r_stall_cnt != '1))
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (o_ifid_flush && (r_flush_cnt != '1))
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;
    assign o_mem_timeout = r_timeout;
    assign o_halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (default and CNT_W=2/TIMEOUT=4) share stimulus,
// a cycle-level model checks every cycle, directed literal checks pin the model.
module tb_hazard_stall_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs_ifid = '0, rt_ifid = '0, rt_idex = '0;
    logic       uses_rt = 1'b0, mem_read = 1'b0, branch = 1'b0, jump = 1'b0;
    logic       mem_access = 1'b0, mem_ready = 1'b0, clr = 1'b0;

    logic [1:0] pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b, tmo, hlt;
    logic [15:0] sc_a, fc_a;
    logic [1:0]  sc_b, fc_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(16), .TIMEOUT(64)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_rs_ifid(rs_ifid), .i_rt_ifid(rt_ifid),
        .i_uses_rt_ifid(uses_rt), .i_mem_read_idex(mem_read), .i_rt_idex(rt_idex),
        .i_branch_taken_id(branch), .i_jump_id(jump), .i_mem_access_exmem(mem_access),
        .i_mem_ready(mem_ready), .i_clear_counters(clr),
        .o_pc_write(pc_w[0]), .o_ifid_write(ifid_w[0]), .o_ifid_flush(ifid_f[0]),
        .o_idex_write(idex_w[0]), .o_idex_flush(idex_f[0]), .o_exmem_write(exmem_w[0]),
        .o_memwb_bubble(memwb_b[0]), .o_stall_count(sc_a), .o_flush_count(fc_a),
        .o_mem_timeout(tmo[0]), .o_halted(hlt[0]));

    hazard_stall_unit #(.CNT_W(2), .TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rs_ifid(rs_ifid), .i_rt_ifid(rt_ifid),
        .i_uses_rt_ifid(uses_rt), .i_mem_read_idex(mem_read), .i_rt_idex(rt_idex),
        .i_branch_taken_id(branch), .i_jump_id(jump), .i_mem_access_exmem(mem_access),
        .i_mem_ready(mem_ready), .i_clear_counters(clr),
        .o_pc_write(pc_w[1]), .o_ifid_write(ifid_w[1]), .o_ifid_flush(ifid_f[1]),
        .o_idex_write(idex_w[1]), .o_idex_flush(idex_f[1]), .o_exmem_write(exmem_w[1]),
        .o_memwb_bubble(memwb_b[1]), .o_stall_count(sc_b), .o_flush_count(fc_b),
        .o_mem_timeout(tmo[1]), .o_halted(hlt[1]));

    // Model: freeze cycles of the current access, halt/timeout flags, counters.
    int mw[2]   = '{0, 0};
    bit mh[2]   = '{0, 0};
    bit mt[2]   = '{0, 0};
    int msc[2]  = '{0, 0};
    int mfc[2]  = '{0, 0};
    int TOUT[2] = '{64, 4};
    int MAXC[2] = '{65535, 3};

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_lu();
        return mem_read && (rt_idex != 0) &&
               ((rt_idex == rs_ifid) || (uses_rt && (rt_idex == rt_ifid)));
    endfunction

    function automatic bit m_fz(input int k);
        return mh[k] || (!mem_ready && ((mw[k] > 0) || mem_access));
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble}
    function automatic logic [6:0] m_ctl(input int k);
        if (rst)                 return 7'b0000000;
        if (m_fz(k))             return 7'b0000001;
        if (m_lu())              return 7'b0001110;
        if (branch || jump)      return 7'b1111010;
        return 7'b1101010;
    endfunction

    function automatic logic [6:0] d_ctl(input int k);
        return {pc_w[k], ifid_w[k], ifid_f[k], idex_w[k], idex_f[k], exmem_w[k], memwb_b[k]};
    endfunction

    // Compare on each falling edge, then advance the model with the inputs the next rising edge samples.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [6:0] c;
                bit fz;
                chk($sformatf("ctl[%0d]", k), int'(d_ctl(k)), int'(m_ctl(k)));
                chk($sformatf("stall_count[%0d]", k), (k == 0) ? int'(sc_a) : int'(sc_b), msc[k]);
                chk($sformatf("flush_count[%0d]", k), (k == 0) ? int'(fc_a) : int'(fc_b), mfc[k]);
                chk($sformatf("tmo_halt[%0d]", k), int'({tmo[k], hlt[k]}), int'({mt[k], mh[k]}));
                c  = m_ctl(k);
                fz = m_fz(k);
                if (rst) begin
                    mw[k] = 0; mh[k] = 0; mt[k] = 0; msc[k] = 0; mfc[k] = 0;
                end else begin
                    if (clr) begin
                        msc[k] = 0; mfc[k] = 0;
                    end else begin
                        if ((fz || m_lu()) && msc[k] < MAXC[k]) msc[k]++;
                        if (c[4] && mfc[k] < MAXC[k]) mfc[k]++;
                    end
                    if (!mh[k]) begin
                        if (fz) begin
                            mw[k]++;
                            if (mw[k] == TOUT[k]) begin mh[k] = 1; mt[k] = 1; mw[k] = 0; end
                        end else mw[k] = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rs_ifid = 0; rt_ifid = 0; rt_idex = 0; uses_rt = 0; mem_read = 0;
        branch = 0; jump = 0; mem_access = 0; mem_ready = 0; clr = 0;
    endtask

    task automatic lu_rs(input logic [4:0] r);
        mem_read = 1; rt_idex = r; rs_ifid = r;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        chk("rst pc_write", int'(pc_w[0]), 0);
        chk("rst memwb_bubble", int'(memwb_b[0]), 0);
        step(); step();
        rst = 0;
        chk("rst stall_count", int'(sc_a), 0);
        chk("rst halted", int'(hlt[0]), 0);

        // load-use on rs
        lu_rs(5'd8);
        @(negedge clk);
        chk("lu pc_write", int'(pc_w[0]), 0);
        chk("lu ifid_write", int'(ifid_w[0]), 0);
        chk("lu idex_flush", int'(idex_f[0]), 1);
        step();
        chk("lu stall_count", int'(sc_a), 1);
        idle(); lu_rs(5'd0);
        @(negedge clk);
        chk("r0 no stall", int'(pc_w[0]), 1);
        step();

        // rt gating
        idle(); mem_read = 1; rt_idex = 9; rt_ifid = 9; rs_ifid = 1;
        @(negedge clk);
        chk("rt unused no stall", int'(pc_w[0]), 1);
        step();
        uses_rt = 1;
        @(negedge clk);
        chk("rt used idex_flush", int'(idex_f[0]), 1);
        step();
        chk("rt stall_count", int'(sc_a), 2);

        // branch flush and priority
        idle(); branch = 1;
        @(negedge clk);
        chk("br ifid_flush", int'(ifid_f[0]), 1);
        step();
        chk("br flush_count", int'(fc_a), 1);
        lu_rs(5'd3);
        @(negedge clk);
        chk("br+lu ifid_flush", int'(ifid_f[0]), 0);
        chk("br+lu idex_flush", int'(idex_f[0]), 1);
        step();
        chk("br+lu flush_count", int'(fc_a), 1);
        idle(); jump = 1;
        step();
        chk("jump flush_count", int'(fc_a), 2);

        // memory wait: 3 frozen cycles then release
        idle(); mem_access = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            branch = (i == 1);
            @(negedge clk);
            chk("wait exmem_write", int'(exmem_w[0]), 0);
            chk("wait memwb_bubble", int'(memwb_b[0]), 1);
            chk("wait ifid_flush", int'(ifid_f[0]), 0);
            step();
        end
        branch = 0; mem_ready = 1;
        @(negedge clk);
        chk("release pc_write", int'(pc_w[0]), 1);
        step();
        chk("wait stall_count", int'(sc_a), 6);
        chk("wait b no timeout", int'(tmo[1]), 0);

        // in WAIT the freeze follows mem_ready alone
        idle(); mem_access = 1; step();
        mem_access = 0;
        @(negedge clk);
        chk("wait no access freeze", int'(pc_w[0]), 0);
        step();
        mem_ready = 1; step();
        idle(); mem_access = 1; mem_ready = 1;
        @(negedge clk);
        chk("ready first no freeze", int'(pc_w[0]), 1);
        step();

        // timeout: b halts after 4 freeze cycles, a after 64
        idle(); mem_access = 1;
        repeat (3) step();
        chk("b pre-timeout", int'(tmo[1]), 0);
        step();
        chk("b timeout", int'(tmo[1]), 1);
        chk("b halted", int'(hlt[1]), 1);
        repeat (59) step();
        chk("a pre-timeout", int'(tmo[0]), 0);
        step();
        chk("a timeout", int'(tmo[0]), 1);
        mem_ready = 1;
        @(negedge clk);
        chk("halt freeze persists", int'(pc_w[0]), 0);
        step();
        rst = 1; step(); rst = 0;
        chk("rst clears timeout", int'(tmo[1]), 0);
        chk("rst clears halted", int'(hlt[1]), 0);
        chk("rst clears stall", int'(sc_a), 0);

        // rst in WAIT abandons the access
        idle(); mem_access = 1; step(); step();
        rst = 1; step(); rst = 0;
        idle();
        @(negedge clk);
        chk("rst in wait -> run", int'(pc_w[0]), 1);
        step();

        // saturation and clear
        lu_rs(5'd4);
        repeat (5) step();
        chk("sat stall_b", int'(sc_b), 3);
        chk("sat stall_a", int'(sc_a), 5);
        idle(); branch = 1;
        repeat (4) step();
        chk("sat flush_b", int'(fc_b), 3);
        idle(); lu_rs(5'd4); clr = 1; step();
        chk("clear wins", int'(sc_a), 0);
        clr = 0; step();
        chk("after clear", int'(sc_a), 1);
        idle(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
